// File: rtl/reg_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter_if
//
// Bundles the two requester handshakes and the shared register bus that the
// reg_bus_arbiter sits between.
//
//   Requester side (per requester n = 0/1):
//     i_reqN    transaction request, held until ackN
//     i_wrN     1 = write, 0 = read
//     i_addrN   target register address
//     i_wdataN  write data
//     o_ackN    one-cycle completion pulse
//     o_rdataN  read result, valid with ackN and held afterwards
//
//   Bank side:
//     o_addr    shared bus address
//     o_data    shared bus write data
//     o_wr      shared bus write strobe (single-cycle)
//     i_rdata   decoded read-back from the banks, registered by the banks
//
//   Status:
//     o_busy    high whenever the arbiter is not idle
//
// Modports:
//   slave   the arbiter's view
//   master  the surrounding logic (requesters, banks, bench)
// ---------------------------------------------------------------------------
interface reg_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic                  i_req0;
  logic                  i_req1;
  logic                  i_wr0;
  logic                  i_wr1;
  logic [ADDR_WIDTH-1:0] i_addr0;
  logic [ADDR_WIDTH-1:0] i_addr1;
  logic [DATA_WIDTH-1:0] i_wdata0;
  logic [DATA_WIDTH-1:0] i_wdata1;
  logic                  o_ack0;
  logic                  o_ack1;
  logic [DATA_WIDTH-1:0] o_rdata0;
  logic [DATA_WIDTH-1:0] o_rdata1;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_wr;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  o_busy;

  modport slave (
    input  i_req0, i_req1, i_wr0, i_wr1,
    input  i_addr0, i_addr1, i_wdata0, i_wdata1,
    input  i_rdata,
    output o_ack0, o_ack1, o_rdata0, o_rdata1,
    output o_addr, o_data, o_wr, o_busy
  );

  modport master (
    output i_req0, i_req1, i_wr0, i_wr1,
    output i_addr0, i_addr1, i_wdata0, i_wdata1,
    output i_rdata,
    input  o_ack0, o_ack1, o_rdata0, o_rdata1,
    input  o_addr, o_data, o_wr, o_busy
  );

endinterface

// File: rtl/reg_bus_arbiter.sv
// ---------------------------------------------------------------------------
// reg_bus_arbiter
//
// Two-requester arbiter/sequencer for the shared configuration register bus
// on i_clk_10. Each requester issues single-word reads or writes with a
// req/ack handshake; the arbiter serialises them onto one addr/data/wr bus
// and absorbs the banks' one-cycle registered read latency.
//
// Transaction timing (cycle 0 = IDLE cycle in which the request is taken):
//   write : cycle 1 bus write (o_wr=1), cycle 2 ack, cycle 3 IDLE
//   read  : cycle 1 bus address, cycle 2 capture i_rdata, cycle 3 ack
//           with o_rdataN valid, cycle 4 IDLE
//
// Parameters:
//   ADDR_WIDTH   register address width
//   DATA_WIDTH   register data width
//   ROUND_ROBIN  1 = alternate under contention, 0 = requester 0 always wins
//
// Ports:
//   i_clk_10     system clock, 10 MHz
//   i_rst        synchronous active-high reset
//   bus          reg_bus_arbiter_if.slave (requester handshakes + bank bus)
// ---------------------------------------------------------------------------
module reg_bus_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                 i_clk_10,
  input  logic                 i_rst,
  reg_bus_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state;
  logic                  gnt;
  logic                  last;

  logic                  winner;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Winner selection is only consumed in IDLE. "last" starts at 1 so that
  // requester 0 wins the first contention in round-robin mode.
  always_comb begin
    winner = 1'b0;
    if (bus.i_req0 && bus.i_req1) begin
      winner = (ROUND_ROBIN != 0) ? ~last : 1'b0;
    end else if (bus.i_req1) begin
      winner = 1'b1;
    end
    sel_wr    = winner ? bus.i_wr1    : bus.i_wr0;
    sel_addr  = winner ? bus.i_addr1  : bus.i_addr0;
    sel_wdata = winner ? bus.i_wdata1 : bus.i_wdata0;
  end

  always_ff @(posedge i_clk_10) begin
    if (i_rst) begin
      state        <= IDLE;
      gnt          <= 1'b0;
      last         <= 1'b1;
      bus.o_addr   <= '0;
      bus.o_data   <= '0;
      bus.o_wr     <= 1'b0;
      bus.o_ack0   <= 1'b0;
      bus.o_ack1   <= 1'b0;
      bus.o_rdata0 <= '0;
      bus.o_rdata1 <= '0;
      bus.o_busy   <= 1'b0;
    end else begin
      // Acks are single-cycle: cleared every cycle unless set below.
      bus.o_ack0 <= 1'b0;
      bus.o_ack1 <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.i_req0 || bus.i_req1) begin
            gnt        <= winner;
            last       <= winner;
            bus.o_wr   <= sel_wr;
            bus.o_addr <= sel_addr;
            bus.o_data <= sel_wdata;
            bus.o_busy <= 1'b1;
            state      <= XFER;
          end
        end

        XFER: begin
          // The banks sample the bus at this edge; the strobe drops here so
          // it is never high for more than one cycle. o_wr still holds the
          // latched direction of the current transaction.
          bus.o_wr <= 1'b0;
          if (bus.o_wr) begin
            if (gnt) bus.o_ack1 <= 1'b1;
            else     bus.o_ack0 <= 1'b1;
            state <= DONE;
          end else begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          // Banks registered the read word at the XFER edge.
          if (gnt) begin
            bus.o_rdata1 <= bus.i_rdata;
            bus.o_ack1   <= 1'b1;
          end else begin
            bus.o_rdata0 <= bus.i_rdata;
            bus.o_ack0   <= 1'b1;
          end
          state <= DONE;
        end

        DONE: begin
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
module tb_reg_bus_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct {
    bit             wr;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    int             start;
    bit             hold;
  } txn_t;

  typedef struct {
    int            who;
    int            cyc;
    logic [DW-1:0] rdata;
  } ack_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wlog_t;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic          rst;
  logic          sel;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  int total = 0;
  int bad   = 0;

  txn_t  q0[$];
  txn_t  q1[$];
  ack_t  acks[$];
  wlog_t wlog[$];

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_rd [2];
  int            m_last;

  reg_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif0 ();
  reg_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif1 ();

  reg_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1)) u_rr (
    .i_clk_10 (clk),
    .i_rst    (rst),
    .bus      (bif0.slave)
  );

  reg_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0)) u_fp (
    .i_clk_10 (clk),
    .i_rst    (rst),
    .bus      (bif1.slave)
  );

  // Only the selected instance sees requests; the other idles.
  assign bif0.i_req0   = req0 & ~sel;
  assign bif0.i_req1   = req1 & ~sel;
  assign bif1.i_req0   = req0 & sel;
  assign bif1.i_req1   = req1 & sel;
  assign bif0.i_wr0    = wr0;
  assign bif0.i_wr1    = wr1;
  assign bif1.i_wr0    = wr0;
  assign bif1.i_wr1    = wr1;
  assign bif0.i_addr0  = addr0;
  assign bif0.i_addr1  = addr1;
  assign bif1.i_addr0  = addr0;
  assign bif1.i_addr1  = addr1;
  assign bif0.i_wdata0 = wdata0;
  assign bif0.i_wdata1 = wdata1;
  assign bif1.i_wdata0 = wdata0;
  assign bif1.i_wdata1 = wdata1;

  // Register bank model: synchronous write, registered read-back.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] bank_q0, bank_q1;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en)     mem[pl_addr]     <= pl_data;
    if (bif0.o_wr) mem[bif0.o_addr] <= bif0.o_data;
    if (bif1.o_wr) mem[bif1.o_addr] <= bif1.o_data;
    bank_q0 <= mem[bif0.o_addr];
    bank_q1 <= mem[bif1.o_addr];
  end
  assign bif0.i_rdata = bank_q0;
  assign bif1.i_rdata = bank_q1;

  logic          m_ack0, m_ack1, m_wr, m_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rdata0, m_rdata1;
  assign m_ack0   = sel ? bif1.o_ack0   : bif0.o_ack0;
  assign m_ack1   = sel ? bif1.o_ack1   : bif0.o_ack1;
  assign m_wr     = sel ? bif1.o_wr     : bif0.o_wr;
  assign m_busy   = sel ? bif1.o_busy   : bif0.o_busy;
  assign m_addr   = sel ? bif1.o_addr   : bif0.o_addr;
  assign m_data   = sel ? bif1.o_data   : bif0.o_data;
  assign m_rdata0 = sel ? bif1.o_rdata0 : bif0.o_rdata0;
  assign m_rdata1 = sel ? bif1.o_rdata1 : bif0.o_rdata1;

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    m_last = 1;
  endtask

  function automatic txn_t rnd_txn(input int start);
    txn_t t;
    t.wr    = 1'($urandom);
    t.addr  = AW'($urandom);
    t.wdata = DW'($urandom);
    t.start = start;
    t.hold  = 1'($urandom);
    return t;
  endfunction

  // Cycle-level reference: every grant schedules its bus cycle at +1 and its
  // ack at +2 (write) or +3 (read); the next grant can happen one cycle later.
  task automatic run_model(input int limit, input bit rr);
    bit            pend [2];
    txn_t          cur [2];
    int            cool [2];
    int            g_cyc, a_cyc, t_who, cyc;
    bit            t_wr, done, e_wr, e_a0, e_a1, e_busy;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_data, t_rd;
    pend[0] = 0; pend[1] = 0; cool[0] = 0; cool[1] = 0;
    g_cyc = -10; a_cyc = -10; t_who = 0; t_wr = 0; cyc = 0; done = 0;
    t_addr = '0; t_data = '0; t_rd = '0;
    acks.delete(); wlog.delete();
    while (!done) begin
      @(posedge clk); #1;
      if (!pend[0] && cyc >= cool[0] && q0.size() > 0 && cyc >= q0[0].start) begin
        cur[0] = q0.pop_front(); pend[0] = 1;
      end
      if (!pend[1] && cyc >= cool[1] && q1.size() > 0 && cyc >= q1[0].start) begin
        cur[1] = q1.pop_front(); pend[1] = 1;
      end
      req0   = pend[0];
      wr0    = pend[0] ? cur[0].wr    : 1'($urandom);
      addr0  = pend[0] ? cur[0].addr  : AW'($urandom);
      wdata0 = pend[0] ? cur[0].wdata : DW'($urandom);
      req1   = pend[1];
      wr1    = pend[1] ? cur[1].wr    : 1'($urandom);
      addr1  = pend[1] ? cur[1].addr  : AW'($urandom);
      wdata1 = pend[1] ? cur[1].wdata : DW'($urandom);
      if (cyc > a_cyc && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) t_who = rr ? 1 - m_last : 0;
        else                    t_who = pend[1] ? 1 : 0;
        m_last = t_who;
        t_wr   = cur[t_who].wr;
        t_addr = cur[t_who].addr;
        t_data = cur[t_who].wdata;
        g_cyc  = cyc;
        a_cyc  = cyc + (t_wr ? 2 : 3);
        if (t_wr) ref_mem[t_addr] = t_data;
        else      t_rd = ref_mem[t_addr];
      end
      @(negedge clk);
      e_wr = (cyc == g_cyc + 1) && t_wr;
      total++;
      if (m_wr !== e_wr) begin
        bad++; $display("FAIL bus_wr cyc=%0d got=%b want=%b", cyc, m_wr, e_wr);
      end
      if (m_wr === 1'b1) wlog.push_back('{cyc, m_addr, m_data});
      if (cyc == g_cyc + 1) begin
        total++;
        if (m_addr !== t_addr || m_data !== t_data) begin
          bad++; $display("FAIL bus_addr_data cyc=%0d got=%h/%h want=%h/%h", cyc, m_addr, m_data, t_addr, t_data);
        end
      end
      if (cyc == a_cyc) begin
        if (!t_wr) exp_rd[t_who] = t_rd;
        pend[t_who] = 0;
        if (t_who == 0) cool[0] = (q0.size() > 0 && q0[0].hold) ? cyc + 1 : cyc + 2;
        else            cool[1] = (q1.size() > 0 && q1[0].hold) ? cyc + 1 : cyc + 2;
      end
      e_a0   = (cyc == a_cyc) && (t_who == 0);
      e_a1   = (cyc == a_cyc) && (t_who == 1);
      e_busy = (cyc > g_cyc) && (cyc <= a_cyc);
      total++;
      if (m_ack0 !== e_a0) begin bad++; $display("FAIL ack0 cyc=%0d got=%b want=%b", cyc, m_ack0, e_a0); end
      total++;
      if (m_ack1 !== e_a1) begin bad++; $display("FAIL ack1 cyc=%0d got=%b want=%b", cyc, m_ack1, e_a1); end
      if (m_ack0 === 1'b1 || m_ack1 === 1'b1)
        acks.push_back('{(m_ack1 === 1'b1) ? 1 : 0, cyc, (m_ack1 === 1'b1) ? m_rdata1 : m_rdata0});
      total++;
      if (m_rdata0 !== exp_rd[0]) begin bad++; $display("FAIL rdata0 cyc=%0d got=%h want=%h", cyc, m_rdata0, exp_rd[0]); end
      total++;
      if (m_rdata1 !== exp_rd[1]) begin bad++; $display("FAIL rdata1 cyc=%0d got=%h want=%h", cyc, m_rdata1, exp_rd[1]); end
      total++;
      if (m_busy !== e_busy) begin bad++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, m_busy, e_busy); end
      if (q0.size() == 0 && q1.size() == 0 && !pend[0] && !pend[1] && cyc > a_cyc) done = 1;
      cyc++;
      if (!done && cyc >= limit) begin
        total++; bad++;
        $display("FAIL timeout after %0d cycles, want all transactions acked", cyc);
        q0.delete(); q1.delete();
        done = 1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (m_addr   !== '0)   begin bad++; $display("FAIL rst_addr got=%h want=0", m_addr); end
    total++; if (m_data   !== '0)   begin bad++; $display("FAIL rst_data got=%h want=0", m_data); end
    total++; if (m_wr     !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b want=0", m_wr); end
    total++; if (m_ack0   !== 1'b0) begin bad++; $display("FAIL rst_ack0 got=%b want=0", m_ack0); end
    total++; if (m_ack1   !== 1'b0) begin bad++; $display("FAIL rst_ack1 got=%b want=0", m_ack1); end
    total++; if (m_rdata0 !== '0)   begin bad++; $display("FAIL rst_rdata0 got=%h want=0", m_rdata0); end
    total++; if (m_rdata1 !== '0)   begin bad++; $display("FAIL rst_rdata1 got=%h want=0", m_rdata1); end
    total++; if (m_busy   !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", m_busy); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL idle_no_req busy got=%b want=0", m_busy); end
    exp_rd[0] = '0; exp_rd[1] = '0;
    m_last = 1;
  endtask

  task automatic test_write0();
    q0.push_back('{1'b1, 8'h07, 8'h01, 0, 1'b0});
    run_model(50, 1'b1);
    total++;
    if (wlog.size() != 1 || wlog[0].cyc != 1 || wlog[0].addr !== 8'h07 || wlog[0].data !== 8'h01) begin
      bad++; $display("FAIL write0_bus got n=%0d (want one write cyc 1 addr 07 data 01)", wlog.size());
    end
    total++;
    if (acks.size() != 1 || acks[0].who != 0 || acks[0].cyc != 2) begin
      bad++; $display("FAIL write0_ack got n=%0d want one ack0 at cycle 2", acks.size());
    end
  endtask

  task automatic test_read1();
    preload(8'h01, 8'h0A);
    q1.push_back('{1'b0, 8'h01, 8'h5C, 0, 1'b0});
    run_model(50, 1'b1);
    total++;
    if (acks.size() != 1 || acks[0].who != 1 || acks[0].cyc != 3 || acks[0].rdata !== 8'h0A) begin
      bad++; $display("FAIL read1_ack got n=%0d want one ack1 at cycle 3 with rdata 0a", acks.size());
    end
    total++;
    if (wlog.size() != 0) begin bad++; $display("FAIL read1_wr got %0d writes want 0", wlog.size()); end
  endtask

  task automatic test_rr_contention();
    int            who_e [4];
    logic [AW-1:0] adr_e [4];
    int            cyc_e [4];
    who_e = '{0, 1, 0, 1};
    adr_e = '{8'h02, 8'h03, 8'h04, 8'h05};
    cyc_e = '{1, 4, 7, 10};
    apply_reset();
    q0.push_back('{1'b1, 8'h02, 8'h11, 0, 1'b0});
    q0.push_back('{1'b1, 8'h04, 8'h33, 0, 1'b1});
    q1.push_back('{1'b1, 8'h03, 8'h22, 0, 1'b0});
    q1.push_back('{1'b1, 8'h05, 8'h44, 0, 1'b1});
    run_model(100, 1'b1);
    total++;
    if (acks.size() != 4 || wlog.size() != 4) begin
      bad++; $display("FAIL rr_count got acks=%0d writes=%0d want 4/4", acks.size(), wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (acks[i].who != who_e[i] || wlog[i].addr !== adr_e[i] || wlog[i].cyc != cyc_e[i]) begin
          bad++; $display("FAIL rr_order idx=%0d got who=%0d addr=%h cyc=%0d want %0d/%h/%0d",
                          i, acks[i].who, wlog[i].addr, wlog[i].cyc, who_e[i], adr_e[i], cyc_e[i]);
        end
      end
    end
  endtask

  task automatic test_rdata_hold();
    preload(8'h30, 8'h55);
    q1.push_back('{1'b0, 8'h30, 8'h00, 0, 1'b0});
    q0.push_back('{1'b1, 8'h30, 8'h99, 2, 1'b0});
    q0.push_back('{1'b0, 8'h30, 8'h00, 0, 1'b0});
    run_model(100, 1'b1);
    total++;
    if (m_rdata1 !== 8'h55) begin bad++; $display("FAIL rdata_hold1 got=%h want=55", m_rdata1); end
    total++;
    if (acks.size() != 3 || acks[2].who != 0 || acks[2].rdata !== 8'h99) begin
      bad++; $display("FAIL rdata_hold_rb got n=%0d want 3 acks, last ack0 rdata 99", acks.size());
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h30; wdata1 = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (m_busy !== 1'b1 || m_ack1 !== 1'b0) begin
      bad++; $display("FAIL rmid_capture busy=%b ack1=%b want 1/0", m_busy, m_ack1);
    end
    @(posedge clk); #1;
    rst = 1'b0; req1 = 1'b0;
    @(negedge clk);
    total++; if (m_ack0 !== 1'b0 || m_ack1 !== 1'b0) begin bad++; $display("FAIL rmid_ack got=%b%b want=00", m_ack0, m_ack1); end
    total++; if (m_rdata0 !== '0 || m_rdata1 !== '0) begin bad++; $display("FAIL rmid_rdata got=%h/%h want=0/0", m_rdata0, m_rdata1); end
    total++; if (m_busy !== 1'b0 || m_wr !== 1'b0 || m_addr !== '0) begin bad++; $display("FAIL rmid_idle busy=%b wr=%b addr=%h want 0/0/0", m_busy, m_wr, m_addr); end
    @(negedge clk);
    total++; if (m_ack1 !== 1'b0 || m_busy !== 1'b0) begin bad++; $display("FAIL rmid_late ack1=%b busy=%b want 0/0", m_ack1, m_busy); end
    exp_rd[0] = '0; exp_rd[1] = '0;
    m_last = 1;
    q1.push_back('{1'b0, 8'h30, 8'h00, 0, 1'b0});
    run_model(50, 1'b1);
    total++;
    if (acks.size() != 1 || acks[0].cyc != 3 || acks[0].rdata !== 8'h99) begin
      bad++; $display("FAIL rmid_reissue got n=%0d want ack at cycle 3 rdata 99", acks.size());
    end
  endtask

  task automatic test_fixed_priority();
    int who_e [4];
    who_e = '{0, 0, 0, 1};
    q0.push_back('{1'b1, 8'h40, 8'hA0, 0, 1'b0});
    q0.push_back('{1'b1, 8'h41, 8'hA1, 0, 1'b1});
    q0.push_back('{1'b1, 8'h42, 8'hA2, 0, 1'b1});
    q1.push_back('{1'b1, 8'h43, 8'hA3, 0, 1'b0});
    run_model(100, 1'b0);
    total++;
    if (acks.size() != 4) begin
      bad++; $display("FAIL fixed_count got=%0d want=4", acks.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (acks[i].who != who_e[i]) begin
          bad++; $display("FAIL fixed_order idx=%0d got=%0d want=%0d", i, acks[i].who, who_e[i]);
        end
      end
    end
  endtask

  task automatic test_random(input bit rr);
    int s0, s1, n0, n1;
    s0 = 0; s1 = 0; n0 = 0; n1 = 0;
    for (int i = 0; i < 25; i++) begin
      s0 += $urandom_range(0, 8);
      s1 += $urandom_range(0, 8);
      q0.push_back(rnd_txn(s0));
      q1.push_back(rnd_txn(s1));
    end
    run_model(4000, rr);
    foreach (acks[i]) begin
      if (acks[i].who == 0) n0++;
      else                  n1++;
    end
    total++;
    if (n0 != 25 || n1 != 25) begin
      bad++; $display("FAIL random_rr%0d acks got=%0d/%0d want=25/25", rr, n0, n1);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    m_last = 1;
    test_reset();
    for (int i = 0; i < 256; i++) preload(AW'(i), DW'($urandom));
    test_write0();
    test_read1();
    test_rr_contention();
    test_rdata_hold();
    test_reset_mid();
    test_random(1'b1);
    sel = 1'b1;
    apply_reset();
    test_fixed_priority();
    test_random(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
